wb_port_arbiter: RTL and testbench

Writer-side front end for the 32-entry register file write port. Merges the in-order MEM/WB pipeline result stream with out-of-order completions from the long-latency unit (multiplier/divider), buffering the latter in a 2-entry FIFO. Drives the register file's single `regwrite`/`writereg`/`writedata` port from registers and keeps a pending-destination scoreboard for the hazard unit. Sits between the WB stage and the register file.

---
 rtl/wb_port_arbiter_if.sv | 32 +++
 rtl/wb_port_arbiter.sv | 136 +++++++++++++
 tb/tb_wb_port_arbiter.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_port_arbiter_if.sv
// Bus bundle between the WB stage / long-latency unit (master) and the
// register-file write-port arbiter (slave).
interface wb_port_arbiter_if #(
  parameter int N = 32
);
  logic         pipe_valid;
  logic [4:0]   pipe_rd;
  logic [N-1:0] pipe_data;
  logic         pipe_hold;
  logic         lu_issue;
  logic [4:0]   lu_issue_rd;
  logic         lu_valid;
  logic [4:0]   lu_rd;
  logic [N-1:0] lu_data;
  logic         lu_ready;
  logic         regwrite;
  logic [4:0]   writereg;
  logic [N-1:0] writedata;
  logic [31:0]  busy_mask;

  modport master (
    output pipe_valid, pipe_rd, pipe_data, lu_issue, lu_issue_rd,
           lu_valid, lu_rd, lu_data,
    input  pipe_hold, lu_ready, regwrite, writereg, writedata, busy_mask
  );

  modport slave (
    input  pipe_valid, pipe_rd, pipe_data, lu_issue, lu_issue_rd,
           lu_valid, lu_rd, lu_data,
    output pipe_hold, lu_ready, regwrite, writereg, writedata, busy_mask
  );
endinterface

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: merges in-order pipe results with buffered
// long-latency completions and tracks outstanding long-latency destinations.
module wb_port_arbiter #(
  parameter int N          = 32,
  parameter int STARVE_MAX = 4
) (
  input logic             clk,
  input logic             rst,
  wb_port_arbiter_if.slave bus
);

  logic [1:0]   r_count;
  logic         r_wr_ptr;
  logic         r_rd_ptr;
  logic [4:0]   r_fifo_rd   [2];
  logic [N-1:0] r_fifo_data [2];
  logic [3:0]   r_starve;
  logic         r_pipe_hold;
  logic         r_regwrite;
  logic [4:0]   r_writereg;
  logic [N-1:0] r_writedata;
  logic [31:0]  r_busy_mask;

  logic         w_lu_ready;
  logic         w_lu_acc;
  logic         w_sel_a;
  logic         w_sel_b;
  logic         w_sel_c;
  logic         w_push;
  logic         w_pop;
  logic         w_wr_en;
  logic         w_clr_en;
  logic [4:0]   w_src_rd;
  logic [N-1:0] w_src_data;
  logic [3:0]   w_starve_inc;
  logic [31:0]  w_busy_next;

  assign w_lu_ready   = (r_count != 2'd2);
  assign w_lu_acc     = bus.lu_valid && w_lu_ready;
  assign w_starve_inc = r_starve + 4'd1;

  always_comb begin
    w_sel_a    = !r_pipe_hold && bus.pipe_valid && (bus.pipe_rd != 5'd0);
    w_sel_b    = !w_sel_a && (r_count != 2'd0);
    w_sel_c    = !w_sel_a && (r_count == 2'd0) && bus.lu_valid;
    w_src_rd   = 5'd0;
    w_src_data = '0;
    if (w_sel_a) begin
      w_src_rd   = bus.pipe_rd;
      w_src_data = bus.pipe_data;
    end else if (w_sel_b) begin
      w_src_rd   = r_fifo_rd[r_rd_ptr];
      w_src_data = r_fifo_data[r_rd_ptr];
    end else if (w_sel_c) begin
      w_src_rd   = bus.lu_rd;
      w_src_data = bus.lu_data;
    end
    // rd 0 results are still consumed, they just never reach the register file
    w_wr_en  = (w_sel_a || w_sel_b || w_sel_c) && (w_src_rd != 5'd0);
    w_clr_en = w_sel_b || w_sel_c;
    w_push   = w_lu_acc && !w_sel_c;
    w_pop    = w_sel_b;
  end

  genvar gi;
  generate
    for (gi = 0; gi < 32; gi++) begin : g_sb
      if (gi == 0) begin : g_zero
        assign w_busy_next[gi] = 1'b0;
      end else begin : g_bit
        // Issue wins over a completion clearing the same bit.
        assign w_busy_next[gi] =
            (bus.lu_issue && (bus.lu_issue_rd == 5'(gi))) ||
            (r_busy_mask[gi] && !(w_clr_en && (w_src_rd == 5'(gi))));
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_rd[r_wr_ptr]   <= bus.lu_rd;
      r_fifo_data[r_wr_ptr] <= bus.lu_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count     <= 2'd0;
      r_wr_ptr    <= 1'b0;
      r_rd_ptr    <= 1'b0;
      r_starve    <= 4'd0;
      r_pipe_hold <= 1'b0;
      r_regwrite  <= 1'b0;
      r_writereg  <= 5'd0;
      r_writedata <= '0;
      r_busy_mask <= 32'd0;
    end else begin
      if (w_push) r_wr_ptr <= ~r_wr_ptr;
      if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase

      r_regwrite <= w_wr_en;
      if (w_wr_en) begin
        r_writereg  <= w_src_rd;
        r_writedata <= w_src_data;
      end
      r_busy_mask <= w_busy_next;

      // Pipe keeps winning while the FIFO waits: after STARVE_MAX such wins, hold it one cycle.
      if (w_sel_a && (r_count != 2'd0)) begin
        if (w_starve_inc == 4'(STARVE_MAX)) begin
          r_starve    <= 4'd0;
          r_pipe_hold <= 1'b1;
        end else begin
          r_starve    <= w_starve_inc;
          r_pipe_hold <= 1'b0;
        end
      end else begin
        r_starve    <= 4'd0;
        r_pipe_hold <= 1'b0;
      end
    end
  end

  assign bus.lu_ready  = w_lu_ready;
  assign bus.pipe_hold = r_pipe_hold;
  assign bus.regwrite  = r_regwrite;
  assign bus.writereg  = r_writereg;
  assign bus.writedata = r_writedata;
  assign bus.busy_mask = r_busy_mask;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: directed vector table, reset and
// wrap sequences, then random traffic against a queue-based reference model.
module tb_wb_port_arbiter;
  localparam int SM = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  wb_port_arbiter_if #(.N(32)) bus_if ();

  wb_port_arbiter #(.N(32), .STARVE_MAX(SM)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  typedef struct {
    logic        pv;
    logic [4:0]  prd;
    logic [31:0] pd;
    logic        iss;
    logic [4:0]  ird;
    logic        lv;
    logic [4:0]  lrd;
    logic [31:0] ld;
    logic        rw;
    logic [4:0]  wr;
    logic [31:0] wd;
    logic [31:0] busy;
    logic        hold;
    logic        rdy;
  } vec_t;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  // reference model state
  ent_t        mq[$];
  logic [31:0] m_busy;
  int          m_starve;
  bit          m_hold;
  logic        m_rw;
  logic [4:0]  m_wreg;
  logic [31:0] m_wdata;
  logic [4:0]  obs[$];

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  function automatic vec_t mk(logic pv, logic [4:0] prd, logic [31:0] pd,
                              logic iss, logic [4:0] ird,
                              logic lv, logic [4:0] lrd, logic [31:0] ld,
                              logic rw, logic [4:0] wr, logic [31:0] wd,
                              logic [31:0] busy, logic hold, logic rdy);
    vec_t v;
    v.pv = pv; v.prd = prd; v.pd = pd; v.iss = iss; v.ird = ird;
    v.lv = lv; v.lrd = lrd; v.ld = ld; v.rw = rw; v.wr = wr; v.wd = wd;
    v.busy = busy; v.hold = hold; v.rdy = rdy;
    return v;
  endfunction

  task automatic drive(logic pv, logic [4:0] prd, logic [31:0] pd, logic iss,
                       logic [4:0] ird, logic lv, logic [4:0] lrd, logic [31:0] ld);
    bus_if.pipe_valid  = pv;
    bus_if.pipe_rd     = prd;
    bus_if.pipe_data   = pd;
    bus_if.lu_issue    = iss;
    bus_if.lu_issue_rd = ird;
    bus_if.lu_valid    = lv;
    bus_if.lu_rd       = lrd;
    bus_if.lu_data     = ld;
  endtask

  task automatic model_reset();
    mq.delete();
    m_busy = 32'd0; m_starve = 0; m_hold = 1'b0;
    m_rw = 1'b0; m_wreg = 5'd0; m_wdata = 32'd0;
  endtask

  // One cycle of the arbitration rules, evaluated on the inputs currently driven.
  task automatic model_step();
    int   sz;
    bit   a, b, c, acc;
    ent_t e;
    sz  = mq.size();
    a   = !m_hold && bus_if.pipe_valid && (bus_if.pipe_rd != 0);
    b   = !a && (sz > 0);
    c   = !a && !b && bus_if.lu_valid;
    acc = bus_if.lu_valid && (sz < 2);
    m_rw = 1'b0;
    if (a) begin
      m_rw = 1'b1; m_wreg = bus_if.pipe_rd; m_wdata = bus_if.pipe_data;
    end else if (b) begin
      e = mq.pop_front();
      if (e.rd != 0) begin m_rw = 1'b1; m_wreg = e.rd; m_wdata = e.data; end
      m_busy[e.rd] = 1'b0;
    end else if (c) begin
      if (bus_if.lu_rd != 0) begin
        m_rw = 1'b1; m_wreg = bus_if.lu_rd; m_wdata = bus_if.lu_data;
      end
      m_busy[bus_if.lu_rd] = 1'b0;
    end
    if (acc && !c) begin
      e.rd = bus_if.lu_rd; e.data = bus_if.lu_data;
      mq.push_back(e);
    end
    if (a && sz > 0) begin
      m_starve++;
      if (m_starve >= SM) begin m_hold = 1'b1; m_starve = 0; end
      else m_hold = 1'b0;
    end else begin
      m_starve = 0; m_hold = 1'b0;
    end
    if (bus_if.lu_issue && bus_if.lu_issue_rd != 0) m_busy[bus_if.lu_issue_rd] = 1'b1;
    m_busy[0] = 1'b0;
  endtask

  task automatic step(string tag);
    model_step();
    @(posedge clk);
    #1;
    cyc++;
    chk({tag, " regwrite"}, 32'(bus_if.regwrite), 32'(m_rw));
    if (m_rw) begin
      chk({tag, " writereg"}, 32'(bus_if.writereg), 32'(m_wreg));
      chk({tag, " writedata"}, bus_if.writedata, m_wdata);
    end
    chk({tag, " busy_mask"}, bus_if.busy_mask, m_busy);
    chk({tag, " pipe_hold"}, 32'(bus_if.pipe_hold), 32'(m_hold));
    chk({tag, " lu_ready"}, 32'(bus_if.lu_ready), 32'(mq.size() < 2));
    if (bus_if.regwrite && bus_if.writereg >= 1 && bus_if.writereg <= 6)
      obs.push_back(bus_if.writereg);
    $display("%s cyc %0d: rw=%b rd=%0d data=%h busy=%h hold=%b rdy=%b", tag, cyc,
             bus_if.regwrite, bus_if.writereg, bus_if.writedata, bus_if.busy_mask,
             bus_if.pipe_hold, bus_if.lu_ready);
  endtask

  vec_t vt[17];

  initial begin
    int idx;
    int bound;
    bit accepted;

    vt[0]  = mk(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0,       1, 5, 32'hDEADBEEF, 0, 0, 1);
    vt[1]  = mk(1, 0, 32'h1234,     0, 0, 0, 0, 0,       0, 0, 0,            0, 0, 1);
    vt[2]  = mk(0, 0, 0,            1, 7, 0, 0, 0,       0, 0, 0,    32'h80,     0, 1);
    vt[3]  = mk(0, 0, 0,            0, 0, 1, 7, 32'h12,  1, 7, 32'h12,       0, 0, 1);
    vt[4]  = mk(0, 0, 0,            1, 9, 0, 0, 0,       0, 0, 0,    32'h200,    0, 1);
    vt[5]  = mk(0, 0, 0,            1, 9, 1, 9, 32'h99,  1, 9, 32'h99, 32'h200,  0, 1);
    vt[6]  = mk(0, 0, 0,            0, 0, 1, 9, 32'h55,  1, 9, 32'h55,       0, 0, 1);
    vt[7]  = mk(0, 0, 0,            0, 0, 1, 0, 32'h77,  0, 0, 0,            0, 0, 1);
    vt[8]  = mk(1, 10, 32'hA0,      0, 0, 1, 3, 32'h33,  1, 10, 32'hA0,      0, 0, 1);
    vt[9]  = mk(1, 11, 32'hA1,      0, 0, 1, 4, 32'h44,  1, 11, 32'hA1,      0, 0, 0);
    vt[10] = mk(1, 12, 32'hA2,      0, 0, 0, 0, 0,       1, 12, 32'hA2,      0, 0, 0);
    vt[11] = mk(1, 13, 32'hA3,      0, 0, 0, 0, 0,       1, 13, 32'hA3,      0, 0, 0);
    vt[12] = mk(1, 14, 32'hA4,      0, 0, 0, 0, 0,       1, 14, 32'hA4,      0, 1, 0);
    vt[13] = mk(1, 15, 32'hA5,      0, 0, 0, 0, 0,       1, 3, 32'h33,       0, 0, 1);
    vt[14] = mk(1, 15, 32'hA5,      0, 0, 0, 0, 0,       1, 15, 32'hA5,      0, 0, 1);
    vt[15] = mk(0, 0, 0,            0, 0, 0, 0, 0,       1, 4, 32'h44,       0, 0, 1);
    vt[16] = mk(0, 0, 0,            0, 0, 0, 0, 0,       0, 0, 0,            0, 0, 1);

    drive(0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    #2;
    chk("reset regwrite", 32'(bus_if.regwrite), 32'd0);
    chk("reset busy_mask", bus_if.busy_mask, 32'd0);
    chk("reset pipe_hold", 32'(bus_if.pipe_hold), 32'd0);
    chk("reset lu_ready", 32'(bus_if.lu_ready), 32'd1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 17; i++) begin
      drive(vt[i].pv, vt[i].prd, vt[i].pd, vt[i].iss, vt[i].ird,
            vt[i].lv, vt[i].lrd, vt[i].ld);
      @(posedge clk);
      #1;
      cyc++;
      chk($sformatf("vec%0d regwrite", i), 32'(bus_if.regwrite), 32'(vt[i].rw));
      if (vt[i].rw) begin
        chk($sformatf("vec%0d writereg", i), 32'(bus_if.writereg), 32'(vt[i].wr));
        chk($sformatf("vec%0d writedata", i), bus_if.writedata, vt[i].wd);
      end
      chk($sformatf("vec%0d busy_mask", i), bus_if.busy_mask, vt[i].busy);
      chk($sformatf("vec%0d pipe_hold", i), 32'(bus_if.pipe_hold), 32'(vt[i].hold));
      chk($sformatf("vec%0d lu_ready", i), 32'(bus_if.lu_ready), 32'(vt[i].rdy));
      $display("vec%0d: rw=%b rd=%0d data=%h busy=%h hold=%b rdy=%b", i,
               bus_if.regwrite, bus_if.writereg, bus_if.writedata,
               bus_if.busy_mask, bus_if.pipe_hold, bus_if.lu_ready);
    end

    // Build up state, then assert reset asynchronously mid-cycle.
    drive(1, 1, 32'h11, 1, 12, 1, 2, 32'h22);
    step("prerst");
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    rst = 1'b1;
    #1;
    chk("async regwrite", 32'(bus_if.regwrite), 32'd0);
    chk("async writereg", 32'(bus_if.writereg), 32'd0);
    chk("async writedata", bus_if.writedata, 32'd0);
    chk("async busy_mask", bus_if.busy_mask, 32'd0);
    chk("async pipe_hold", 32'(bus_if.pipe_hold), 32'd0);
    chk("async lu_ready", 32'(bus_if.lu_ready), 32'd1);
    $display("async reset: rw=%b busy=%h rdy=%b", bus_if.regwrite, bus_if.busy_mask,
             bus_if.lu_ready);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    step("postrst");

    // Six lu results through the FIFO with the pipe alternating busy/idle.
    obs.delete();
    idx   = 1;
    bound = 0;
    while ((idx <= 6 || obs.size() < 6) && bound < 80) begin
      drive(bound % 2 == 0, 5'(20 + (bound % 8)), 32'h900 + 32'(bound), 0, 0,
            idx <= 6, 5'(idx <= 6 ? idx : 0), 32'h100 + 32'(idx));
      accepted = bus_if.lu_valid && bus_if.lu_ready;
      step("wrap");
      if (accepted) idx++;
      bound++;
    end
    chk("wrap count", 32'(obs.size()), 32'd6);
    for (int i = 0; i < 6; i++) begin
      if (i < obs.size()) chk($sformatf("wrap order%0d", i), 32'(obs[i]), 32'(i + 1));
    end

    for (int i = 0; i < 300; i++) begin
      drive(($urandom % 4) != 0, 5'($urandom % 32), $urandom,
            ($urandom % 5) == 0, 5'($urandom % 32),
            ($urandom % 2) == 0, 5'($urandom % 32), $urandom);
      step("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
